// File: rtl/bike_motion_ctrl_pkg.sv
// Shared lightbike constants: screen geometry, heading codes, descriptor field layout,
// FSM and pending-turn encodings, and the pixel address helper.
package bike_motion_ctrl_pkg;

    localparam int unsigned SCR_W = 640;
    localparam int unsigned SCR_H = 480;
    localparam int unsigned SPR   = 30;

    localparam logic [1:0] ORIENT_UP    = 2'b00;
    localparam logic [1:0] ORIENT_RIGHT = 2'b01;
    localparam logic [1:0] ORIENT_DOWN  = 2'b10;
    localparam logic [1:0] ORIENT_LEFT  = 2'b11;

    localparam int unsigned BIKE_OR_LSB   = 0;
    localparam int unsigned BIKE_OR_MSB   = 1;
    localparam int unsigned BIKE_ADDR_LSB = 2;
    localparam int unsigned BIKE_ADDR_MSB = 20;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CRASH} state_t;
    typedef enum logic [1:0] {PT_NONE, PT_L, PT_R} turn_t;

    // y*640 + x as two shifts and adds
    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] w_y;
        w_y = {9'b0, y};
        return (w_y << 9) + (w_y << 7) + {9'b0, x};
    endfunction

endpackage

// File: rtl/bike_motion_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector producing a single-cycle pulse per press.
module btn_sync_edge (
    input  logic iRST_n,
    input  logic iVGA_CLK,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/bike_motion_ctrl.sv
// Bike position/heading controller: steps the sprite origin on vsync frame ticks,
// applies pending button turns, detects wall crashes and emits the descriptor word.
module bike_motion_ctrl
    import bike_motion_ctrl_pkg::*;
#(
    parameter int unsigned SCR_W           = bike_motion_ctrl_pkg::SCR_W,
    parameter int unsigned SCR_H           = bike_motion_ctrl_pkg::SCR_H,
    parameter int unsigned SPR             = bike_motion_ctrl_pkg::SPR,
    parameter int unsigned STEP            = 2,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned START_X         = 305,
    parameter int unsigned START_Y         = 225,
    parameter logic [1:0]  START_DIR       = 2'b00
) (
    input  logic        iRST_n,
    input  logic        iVGA_CLK,
    input  logic        iVS,
    input  logic        iBtnLeft,
    input  logic        iBtnRight,
    input  logic        iStart,
    output logic [31:0] oBike,
    output logic        oCrashed,
    output logic        oFrameTick
);

    localparam int unsigned FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);
    localparam logic [10:0] W_STEP = 11'(STEP);
    localparam logic [10:0] X_MAX  = 11'(SCR_W - SPR);
    localparam logic [10:0] Y_MAX  = 11'(SCR_H - SPR);
    localparam logic [9:0]  X0     = 10'(START_X);
    localparam logic [9:0]  Y0     = 10'(START_Y);

    logic w_left, w_right, w_start;
    logic r_vs_d, w_tick, w_step_en;

    state_t         r_state, w_state_nx;
    turn_t          r_pt, w_pt_nx;
    logic [FCW-1:0] r_fc, w_fc_nx;
    logic [9:0]     r_x, r_y, w_x_nx, w_y_nx, w_x_st, w_y_st;
    logic [1:0]     r_or, w_or_nx, w_head;
    logic           w_crash, w_bike_ld;
    logic [31:0]    r_bike;

    btn_sync_edge u_left  (.iRST_n(iRST_n), .iVGA_CLK(iVGA_CLK), .i_btn(iBtnLeft),  .o_pulse(w_left));
    btn_sync_edge u_right (.iRST_n(iRST_n), .iVGA_CLK(iVGA_CLK), .i_btn(iBtnRight), .o_pulse(w_right));
    btn_sync_edge u_start (.iRST_n(iRST_n), .iVGA_CLK(iVGA_CLK), .i_btn(iStart),    .o_pulse(w_start));

    assign w_tick    = r_vs_d & ~iVS;
    assign w_step_en = w_tick & (r_fc == FC_LAST);

    always_comb begin
        w_head = r_or;
        case (r_pt)
            PT_L:    w_head = r_or - 2'd1;
            PT_R:    w_head = r_or + 2'd1;
            default: w_head = r_or;
        endcase
    end

    always_comb begin
        w_crash = 1'b0;
        w_x_st  = r_x;
        w_y_st  = r_y;
        case (w_head)
            ORIENT_UP: begin
                w_crash = {1'b0, r_y} < W_STEP;
                w_y_st  = r_y - W_STEP[9:0];
            end
            ORIENT_DOWN: begin
                w_crash = ({1'b0, r_y} + W_STEP) > Y_MAX;
                w_y_st  = r_y + W_STEP[9:0];
            end
            ORIENT_LEFT: begin
                w_crash = {1'b0, r_x} < W_STEP;
                w_x_st  = r_x - W_STEP[9:0];
            end
            default: begin
                w_crash = ({1'b0, r_x} + W_STEP) > X_MAX;
                w_x_st  = r_x + W_STEP[9:0];
            end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_pt_nx    = r_pt;
        w_fc_nx    = r_fc;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_or_nx    = r_or;
        w_bike_ld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pt_nx = PT_NONE;
                w_fc_nx = '0;
                if (w_start) w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (w_left && !w_right)
                    w_pt_nx = (r_pt == PT_R) ? PT_NONE : PT_L;
                else if (w_right && !w_left)
                    w_pt_nx = (r_pt == PT_L) ? PT_NONE : PT_R;
                if (w_tick) w_fc_nx = (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
                if (w_step_en) begin
                    w_pt_nx   = PT_NONE;
                    w_or_nx   = w_head;
                    w_bike_ld = 1'b1;
                    if (w_crash) begin
                        w_state_nx = ST_CRASH;
                    end else begin
                        w_x_nx = w_x_st;
                        w_y_nx = w_y_st;
                    end
                end
            end
            default: begin
                w_pt_nx = PT_NONE;
                w_fc_nx = '0;
                if (w_start) begin
                    w_x_nx     = X0;
                    w_y_nx     = Y0;
                    w_or_nx    = START_DIR;
                    w_bike_ld  = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_vs_d  <= 1'b0;
            r_state <= ST_IDLE;
            r_pt    <= PT_NONE;
            r_fc    <= '0;
            r_x     <= X0;
            r_y     <= Y0;
            r_or    <= START_DIR;
            r_bike  <= {11'b0, pix_addr(X0, Y0), START_DIR};
        end else begin
            r_vs_d  <= iVS;
            r_state <= w_state_nx;
            r_pt    <= w_pt_nx;
            r_fc    <= w_fc_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_or    <= w_or_nx;
            if (w_bike_ld) r_bike <= {11'b0, pix_addr(w_x_nx, w_y_nx), w_or_nx};
        end
    end

    assign oBike      = r_bike;
    assign oCrashed   = (r_state == ST_CRASH);
    assign oFrameTick = w_tick;

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Directed self-checking bench for bike_motion_ctrl: default instance plus a
// FRAMES_PER_STEP=3 instance sharing clock, reset and vsync.
module tb_bike_motion_ctrl;

    localparam logic [31:0] RESET_WORD = 32'h0008CEC4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    logic bl = 1'b0, br = 1'b0, st = 1'b0, st3 = 1'b0;
    logic [31:0] bike, bike3;
    logic crashed, crashed3, ftick, ftick3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bike_motion_ctrl dut (
        .iRST_n(rst_n), .iVGA_CLK(clk), .iVS(vs), .iBtnLeft(bl), .iBtnRight(br),
        .iStart(st), .oBike(bike), .oCrashed(crashed), .oFrameTick(ftick)
    );

    bike_motion_ctrl #(.FRAMES_PER_STEP(3)) dut3 (
        .iRST_n(rst_n), .iVGA_CLK(clk), .iVS(vs), .iBtnLeft(1'b0), .iBtnRight(1'b0),
        .iStart(st3), .oBike(bike3), .oCrashed(crashed3), .oFrameTick(ftick3)
    );

    function automatic logic [31:0] word(input int x, input int y, input logic [1:0] o);
        return (32'(y * 640 + x) << 2) | {30'b0, o};
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic press(input logic l, input logic r, input logic s, input logic s3);
        @(negedge clk);
        bl = l; br = r; st = s; st3 = s3;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bl = 1'b0; br = 1'b0; st = 1'b0; st3 = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic tick_begin();
        @(negedge clk); vs = 1'b0; #1;
    endtask

    task automatic tick_finish();
        @(posedge clk); #1;
    endtask

    task automatic tick_release();
        @(negedge clk); vs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic tick();
        tick_begin(); tick_finish(); tick_release();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bike !== RESET_WORD) begin errors++; $display("FAIL reset_bike got %h want %h", bike, RESET_WORD); end
        checks++; if (crashed !== 1'b0) begin errors++; $display("FAIL reset_crashed got %b want 0", crashed); end
        checks++; if (ftick !== 1'b0) begin errors++; $display("FAIL reset_ftick got %b want 0", ftick); end
        for (int i = 0; i < 5; i++) begin
            tick_begin();
            checks++; if (ftick !== 1'b1) begin errors++; $display("FAIL idle_ftick%0d got %b want 1", i, ftick); end
            tick_finish();
            checks++; if (bike !== RESET_WORD) begin errors++; $display("FAIL idle_hold%0d got %h want %h", i, bike, RESET_WORD); end
            tick_release();
        end
    endtask

    task automatic test_run_up();
        logic [31:0] prev;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        prev = RESET_WORD;
        for (int i = 1; i <= 3; i++) begin
            tick_begin();
            checks++; if (ftick !== 1'b1 || bike !== prev) begin errors++; $display("FAIL run_pre%0d got tick=%b bike=%h want tick=1 bike=%h", i, ftick, bike, prev); end
            tick_finish();
            prev = word(305, 225 - 2 * i, 2'b00);
            checks++; if (ftick !== 1'b0 || bike !== prev) begin errors++; $display("FAIL run_post%0d got tick=%b bike=%h want tick=0 bike=%h", i, ftick, bike, prev); end
            tick_release();
        end
        checks++; if (bike[20:2] !== 19'd140465 || bike[1:0] !== 2'b00) begin errors++; $display("FAIL run_addr got %0d/%b want 140465/00", bike[20:2], bike[1:0]); end
    endtask

    task automatic test_turns();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bike !== word(305, 219, 2'b00)) begin errors++; $display("FAIL turn_wait got %h want %h", bike, word(305, 219, 2'b00)); end
        tick();
        checks++; if (bike !== word(307, 219, 2'b01)) begin errors++; $display("FAIL turn_right got %h want %h", bike, word(307, 219, 2'b01)); end
        press(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (bike !== word(309, 219, 2'b01)) begin errors++; $display("FAIL turn_both got %h want %h", bike, word(309, 219, 2'b01)); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (bike !== word(311, 219, 2'b01)) begin errors++; $display("FAIL turn_cancel got %h want %h", bike, word(311, 219, 2'b01)); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bike !== word(311, 217, 2'b00)) begin errors++; $display("FAIL turn_left got %h want %h", bike, word(311, 217, 2'b00)); end
    endtask

    task automatic test_crash();
        do_reset();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 112; i++) tick();
        checks++; if (bike !== word(305, 1, 2'b00) || crashed !== 1'b0) begin errors++; $display("FAIL crash_edge got %h c=%b want %h c=0", bike, crashed, word(305, 1, 2'b00)); end
        tick();
        checks++; if (crashed !== 1'b1 || bike !== word(305, 1, 2'b00)) begin errors++; $display("FAIL crash_hit got %h c=%b want %h c=1", bike, crashed, word(305, 1, 2'b00)); end
        tick();
        checks++; if (crashed !== 1'b1 || bike !== word(305, 1, 2'b00)) begin errors++; $display("FAIL crash_hold got %h c=%b want %h c=1", bike, crashed, word(305, 1, 2'b00)); end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (crashed !== 1'b0 || bike !== RESET_WORD) begin errors++; $display("FAIL crash_restart got %h c=%b want %h c=0", bike, crashed, RESET_WORD); end
        tick();
        checks++; if (bike !== RESET_WORD) begin errors++; $display("FAIL crash_idle got %h want %h", bike, RESET_WORD); end
    endtask

    task automatic test_frames_per_step();
        int y;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        y = 225;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i % 3 == 0) y = y - 2;
            checks++; if (bike3 !== word(305, y, 2'b00)) begin errors++; $display("FAIL fps3_tick%0d got %h want %h", i, bike3, word(305, y, 2'b00)); end
            if (i == 4) press(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checks++; if (crashed3 !== 1'b0) begin errors++; $display("FAIL fps3_crashed got %b want 0", crashed3); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tick_begin();
        rst_n = 1'b0;
        #1;
        checks++; if (bike !== RESET_WORD || crashed !== 1'b0 || ftick !== 1'b0) begin errors++; $display("FAIL arst_now got %h c=%b t=%b want %h c=0 t=0", bike, crashed, ftick, RESET_WORD); end
        @(negedge clk); vs = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        checks++; if (bike !== RESET_WORD) begin errors++; $display("FAIL arst_idle got %h want %h", bike, RESET_WORD); end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bike !== word(305, 223, 2'b00)) begin errors++; $display("FAIL arst_noturn got %h want %h", bike, word(305, 223, 2'b00)); end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_turns();
        test_crash();
        test_frames_per_step();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
